// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency sweep sequencer (single, sawtooth, triangle).
// Optional feature macro: DDS_SWEEP_PHASE_RST_EN (phase reset on each sawtooth wrap).
module dds_sweep_ctrl #(
  parameter int PW = 32,
  parameter int TW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [1:0]    i_mode,
  input  logic [PW-1:0] i_f_start,
  input  logic [PW-1:0] i_f_stop,
  input  logic [PW-1:0] i_f_step,
  input  logic [TW-1:0] i_dwell,
  input  logic [PW-1:0] i_phase_off,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_dds_en,
  output logic          o_dds_rst,
  output logic [PW-1:0] o_dds_freq,
  output logic [PW-1:0] o_dds_phase
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_UP, S_DOWN} state_t;

  localparam logic [1:0] M_SAW = 2'd1;
  localparam logic [1:0] M_TRI = 2'd2;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic [PW-1:0] r_f_start, w_f_start_nxt;
  logic [PW-1:0] r_f_stop, w_f_stop_nxt;
  logic [PW-1:0] r_f_step, w_f_step_nxt;
  logic [TW-1:0] r_dwell, w_dwell_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_en, w_en_nxt;
  logic          r_rst, w_rst_nxt;
  logic [PW-1:0] r_freq, w_freq_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;

  logic [PW:0]   w_sum;
  logic [PW:0]   w_diff;
  logic [PW-1:0] w_up_freq;
  logic [PW-1:0] w_dn_freq;
  logic          w_degen;
  logic          w_pt_end;
  logic          w_repeat;

  // Sum/difference carry one extra bit so overflow and borrow clamp to the end points.
  assign w_sum     = {1'b0, r_freq} + {1'b0, r_f_step};
  assign w_diff    = {1'b0, r_freq} - {1'b0, r_f_step};
  assign w_up_freq = (w_sum >= {1'b0, r_f_stop}) ? r_f_stop : w_sum[PW-1:0];
  assign w_dn_freq = (w_diff[PW] || (w_diff[PW-1:0] < r_f_start)) ? r_f_start : w_diff[PW-1:0];
  assign w_degen   = (r_f_start >= r_f_stop);
  assign w_pt_end  = (r_cnt == '0);
  assign w_repeat  = (r_mode == M_SAW) || (r_mode == M_TRI);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_f_start <= '0;
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_dwell   <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_en      <= 1'b0;
      r_rst     <= 1'b0;
      r_freq    <= '0;
      r_phase   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_f_start <= w_f_start_nxt;
      r_f_stop  <= w_f_stop_nxt;
      r_f_step  <= w_f_step_nxt;
      r_dwell   <= w_dwell_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_en      <= w_en_nxt;
      r_rst     <= w_rst_nxt;
      r_freq    <= w_freq_nxt;
      r_phase   <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_f_start_nxt = r_f_start;
    w_f_stop_nxt  = r_f_stop;
    w_f_step_nxt  = r_f_step;
    w_dwell_nxt   = r_dwell;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_en_nxt      = r_en;
    w_rst_nxt     = 1'b0;
    w_freq_nxt    = r_freq;
    w_phase_nxt   = r_phase;

    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_en_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_mode_nxt    = i_mode;
            w_f_start_nxt = i_f_start;
            w_f_stop_nxt  = i_f_stop;
            // A zero step would stall the sweep forever, so it behaves as a step of one.
            w_f_step_nxt  = (i_f_step == '0) ? PW'(1) : i_f_step;
            w_dwell_nxt   = i_dwell;
            w_freq_nxt    = i_f_start;
            w_phase_nxt   = i_phase_off;
            w_busy_nxt    = 1'b1;
            w_rst_nxt     = 1'b1;
            w_en_nxt      = 1'b0;
            w_state_nxt   = S_PRIME;
          end
        end
        S_PRIME: begin
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = r_dwell;
          w_state_nxt = S_UP;
        end
        S_UP: begin
          if (!w_pt_end) begin
            w_cnt_nxt = r_cnt - TW'(1);
          end else begin
            w_cnt_nxt = r_dwell;
            if ((r_freq == r_f_stop) || w_degen) begin
              if (!w_repeat) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_en_nxt    = 1'b0;
              end else if ((r_mode == M_TRI) && !w_degen) begin
                w_freq_nxt  = w_dn_freq;
                w_state_nxt = S_DOWN;
              end else begin
                w_freq_nxt = r_f_start;
`ifdef DDS_SWEEP_PHASE_RST_EN
                w_rst_nxt  = !w_degen;
`else
                w_rst_nxt  = 1'b0;
`endif
              end
            end else begin
              w_freq_nxt = w_up_freq;
            end
          end
        end
        S_DOWN: begin
          if (!w_pt_end) begin
            w_cnt_nxt = r_cnt - TW'(1);
          end else begin
            w_cnt_nxt = r_dwell;
            if (r_freq == r_f_start) begin
              w_freq_nxt  = w_up_freq;
              w_state_nxt = S_UP;
            end else begin
              w_freq_nxt = w_dn_freq;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_dds_en    = r_en;
  assign o_dds_rst   = r_rst;
  assign o_dds_freq  = r_freq;
  assign o_dds_phase = r_phase;

endmodule
